// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches, tracks outstanding
// responses, buffers up to two returned instructions in order and handles
// branch redirects by discarding responses that are still in flight.
module instr_fetch_unit #(
  parameter int unsigned ADDR_WIDTH_P  = 32,
  parameter int unsigned INSTR_WIDTH_P = 32,
  parameter logic [ADDR_WIDTH_P-1:0] RESET_PC_P = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic                     o_imem_req,
  output logic [ADDR_WIDTH_P-1:0]  o_imem_addr,
  input  logic                     i_imem_gnt,
  input  logic                     i_imem_rvalid,
  input  logic [INSTR_WIDTH_P-1:0] i_imem_rdata,
  input  logic                     i_branch_taken,
  input  logic [ADDR_WIDTH_P-1:0]  i_branch_target,
  output logic                     o_instr_valid,
  output logic [INSTR_WIDTH_P-1:0] o_instr,
  output logic [5:0]               o_opcode,
  output logic [5:0]               o_function,
  output logic [ADDR_WIDTH_P-1:0]  o_instr_pc,
  input  logic                     i_instr_ready
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_WIDTH_P-1:0]   pc_q, pc_d;
  logic [1:0]                outstanding_q, outstanding_d;
  logic [1:0]                discard_q, discard_d;
  logic [1:0]                count_q, count_d;
  logic                      head_q, head_d;
  logic [INSTR_WIDTH_P-1:0]  buf_instr_q [2];
  logic [ADDR_WIDTH_P-1:0]   buf_pc_q [2];

  logic       rvalid_eff;
  logic       grant;
  logic       push;
  logic       pop;
  logic       tail_idx;
  logic [2:0] credit_used;
  logic       unused_target_bits;

  // Target low bits are dropped by word alignment.
  assign unused_target_bits = ^i_branch_target[1:0];

  // Responses with nothing outstanding are strays (e.g. issued before reset).
  assign rvalid_eff = i_imem_rvalid && (outstanding_q != 2'd0);
  assign pop        = (count_q != 2'd0) && i_instr_ready && !i_branch_taken;
  assign push       = rvalid_eff && (discard_q == 2'd0) && !i_branch_taken;
  // Slot freed by this cycle's pop counts as available, giving one fetch per cycle.
  assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q} - {2'b00, pop};
  assign tail_idx    = head_q ^ count_q[0];

  // Request and buffer-head outputs.
  always_comb begin
    o_imem_req    = (state_q == S_RUN) && (credit_used < 3'd2) && !i_branch_taken;
    o_imem_addr   = pc_q;
    o_instr_valid = (count_q != 2'd0);
    o_instr       = o_instr_valid ? buf_instr_q[head_q] : '0;
    o_instr_pc    = o_instr_valid ? buf_pc_q[head_q] : '0;
    o_opcode      = o_instr[31:26];
    o_function    = o_instr[5:0];
  end

  assign grant = o_imem_req && i_imem_gnt;

  // Next-state, PC, counters and buffer bookkeeping.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, rvalid_eff};
    discard_d     = discard_q;
    count_d       = count_q + {1'b0, push} - {1'b0, pop};
    head_d        = pop ? ~head_q : head_q;

    if (grant) begin
      pc_d = pc_q + ADDR_WIDTH_P'(4);
    end
    if (rvalid_eff && (discard_q != 2'd0)) begin
      discard_d = discard_q - 2'd1;
    end

    unique case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_FLUSH: if (discard_d == 2'd0) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything: every in-flight response becomes stale.
    if (i_branch_taken) begin
      pc_d      = {i_branch_target[ADDR_WIDTH_P-1:2], 2'b00};
      count_d   = 2'd0;
      head_d    = 1'b0;
      discard_d = outstanding_q - {1'b0, rvalid_eff};
      state_d   = (discard_d != 2'd0) ? S_FLUSH : S_RUN;
    end
  end

  // State and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC_P;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      head_q        <= head_d;
    end
  end

  // Instruction buffer storage, written at the tail on accepted responses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        buf_instr_q[i] <= '0;
        buf_pc_q[i]    <= '0;
      end
    end else if (push) begin
      buf_instr_q[tail_idx] <= i_imem_rdata;
      buf_pc_q[tail_idx]    <= pc_of_response(outstanding_q, pc_q);
    end
  end

  // Address of the oldest outstanding request, recovered from the current PC.
  function automatic logic [ADDR_WIDTH_P-1:0] pc_of_response(input logic [1:0] outstanding,
                                                             input logic [ADDR_WIDTH_P-1:0] pc);
    pc_of_response = pc - ADDR_WIDTH_P'({outstanding, 2'b00});
  endfunction

endmodule
